// File: rtl/decode_stage.sv
// Handshaked instruction decode stage with a two-entry decoded-record buffer.
// Optional illegal-opcode trap is built when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_stage #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned OP_W       = 5,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned COND_W     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IMM_SIGNED = 1,
    parameter int unsigned NUM_OPS    = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   opcode,
    output logic              addr_mode,
    output logic [REG_W-1:0]  reg_idx_a,
    output logic [REG_W-1:0]  reg_idx_b,
    output logic [COND_W-1:0] cond,
    output logic [DATA_W-1:0] imm,
    output logic              illegal,
    output logic              err_sticky
);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic              addr_mode;
        logic [REG_W-1:0]  reg_a;
        logic [REG_W-1:0]  reg_b;
        logic [COND_W-1:0] cond;
        logic [DATA_W-1:0] imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic              illegal;
`endif
    } rec_t;

    rec_t       dec_c;
    rec_t       head_q, head_d;
    rec_t       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push_c, pop_c;

    // Decode the incoming word into a record; fields are stored, never recomputed.
    always_comb begin
        dec_c           = '0;
        dec_c.opcode    = instr[WORD_W-1 -: OP_W];
        dec_c.addr_mode = instr[2*REG_W];
        dec_c.reg_a     = instr[2*REG_W-1 -: REG_W];
        dec_c.reg_b     = instr[REG_W-1:0];
        dec_c.cond      = instr[COND_W-1:0];
        if (IMM_SIGNED != 0) begin
            dec_c.imm = DATA_W'($signed(instr[REG_W-1:0]));
        end else begin
            dec_c.imm = DATA_W'(instr[REG_W-1:0]);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_c.illegal = (32'(dec_c.opcode) >= 32'(NUM_OPS));
`endif
    end

    assign push_c = in_valid && in_ready && !flush;
    assign pop_c  = out_valid && out_ready && !flush;

    // Head entry drives the outputs directly; tail is the second slot.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = dec_c;
                    end else begin
                        tail_d = dec_c;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = dec_c;
                    end else begin
                        head_d = dec_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            out_valid <= (count_d != 2'd0);
            in_ready  <= (count_d != 2'd2);
        end
    end

    assign opcode    = head_q.opcode;
    assign addr_mode = head_q.addr_mode;
    assign reg_idx_a = head_q.reg_a;
    assign reg_idx_b = head_q.reg_b;
    assign cond      = head_q.cond;
    assign imm       = head_q.imm;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic err_sticky_q;

    // Sticky until reset; illegal words still flow downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else if (push_c && dec_c.illegal) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign illegal    = head_q.illegal;
    assign err_sticky = err_sticky_q;
`else
    assign illegal    = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a signed-immediate and an unsigned-immediate instance.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] instr;
    logic        out_ready;

    logic        in_ready, out_valid, addr_mode, illegal, err_sticky;
    logic [4:0]  opcode, reg_idx_a, reg_idx_b;
    logic [3:0]  cond;
    logic [15:0] imm;

    logic        u_in_ready, u_out_valid, u_addr_mode, u_illegal, u_err_sticky;
    logic [4:0]  u_opcode, u_reg_idx_a, u_reg_idx_b;
    logic [3:0]  u_cond;
    logic [15:0] u_imm;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decode_stage #(.IMM_SIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .addr_mode(addr_mode), .reg_idx_a(reg_idx_a), .reg_idx_b(reg_idx_b), .cond(cond),
        .imm(imm), .illegal(illegal), .err_sticky(err_sticky)
    );

    decode_stage #(.IMM_SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
        .instr(instr), .out_valid(u_out_valid), .out_ready(out_ready), .opcode(u_opcode),
        .addr_mode(u_addr_mode), .reg_idx_a(u_reg_idx_a), .reg_idx_b(u_reg_idx_b), .cond(u_cond),
        .imm(u_imm), .illegal(u_illegal), .err_sticky(u_err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = 16'h0; out_ready = 1'b0;
        tick(); tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst opcode", 32'(opcode), 32'd0);
        check("rst imm", 32'(imm), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst err_sticky", 32'(err_sticky), 32'd0);

        // Basic decode; push lands on the first edge after release.
        in_valid = 1'b1; instr = 16'hA9C5; out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        check("a9c5 out_valid", 32'(out_valid), 32'd1);
        check("a9c5 opcode", 32'(opcode), 32'h15);
        check("a9c5 addr_mode", 32'(addr_mode), 32'd0);
        check("a9c5 reg_a", 32'(reg_idx_a), 32'h0E);
        check("a9c5 reg_b", 32'(reg_idx_b), 32'h05);
        check("a9c5 cond", 32'(cond), 32'h5);
        check("a9c5 imm", 32'(imm), 32'h0005);
        tick();
        check("a9c5 drained", 32'(out_valid), 32'd0);

        // Immediate extension, signed vs unsigned instance.
        in_valid = 1'b1; instr = 16'h0413;
        tick();
        in_valid = 1'b0;
        check("0413 addr_mode", 32'(addr_mode), 32'd1);
        check("0413 reg_b", 32'(reg_idx_b), 32'h13);
        check("0413 cond", 32'(cond), 32'h3);
        check("0413 imm signed", 32'(imm), 32'hFFF3);
        check("0413 imm unsigned", 32'(u_imm), 32'h0013);
        check("0413 u opcode", 32'(u_opcode), 32'h00);
        tick();

        // Backpressure: three words with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 16'h0800;
        tick();
        check("bp in_ready after 1", 32'(in_ready), 32'd1);
        instr = 16'h1000;
        tick();
        check("bp in_ready after 2", 32'(in_ready), 32'd0);
        check("bp head w0", 32'(opcode), 32'd1);
        instr = 16'h1800;
        tick();
        check("bp held in_ready", 32'(in_ready), 32'd0);
        check("bp held head", 32'(opcode), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp pop1 head w1", 32'(opcode), 32'd2);
        check("bp pop1 in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp head w2", 32'(opcode), 32'd3);
        check("bp w2 valid", 32'(out_valid), 32'd1);
        tick();
        check("bp drained", 32'(out_valid), 32'd0);

        // Streaming at full rate.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr = {5'(i), 1'b0, 5'(i + 3), 5'(i)};
            tick();
            check("stream valid", 32'(out_valid), 32'd1);
            check("stream opcode", 32'(opcode), 32'(i));
            check("stream reg_a", 32'(reg_idx_a), 32'(i + 3));
            check("stream in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream drained", 32'(out_valid), 32'd0);

        // Flush with a full buffer.
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h0800;
        tick();
        instr = 16'h1000;
        tick();
        check("flush full in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; instr = 16'h2000;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        tick();
        check("flush word dropped", 32'(out_valid), 32'd0);

        // Flush with one entry and an offered word that handshakes.
        in_valid = 1'b1; instr = 16'h0800;
        tick();
        flush = 1'b1; instr = 16'h2800;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush1 out_valid", 32'(out_valid), 32'd0);
        tick();
        check("flush1 dropped", 32'(out_valid), 32'd0);

        // Illegal opcode 30.
        out_ready = 1'b1; in_valid = 1'b1; instr = 16'hF000;
        tick();
        in_valid = 1'b1; instr = 16'h0800;
        check("ill valid", 32'(out_valid), 32'd1);
        check("ill opcode", 32'(opcode), 32'd30);
        check("ill illegal", 32'(illegal), 32'(TRAP));
        check("ill sticky", 32'(err_sticky), 32'(TRAP));
        tick();
        in_valid = 1'b0;
        check("legal illegal", 32'(illegal), 32'd0);
        check("legal opcode", 32'(opcode), 32'd1);
        check("sticky holds", 32'(err_sticky), 32'(TRAP));
        tick(); tick();
        check("sticky holds idle", 32'(err_sticky), 32'(TRAP));
        rst_n = 1'b0;
        #2;
        check("sticky async clear", 32'(err_sticky), 32'd0);
        check("async out_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst sticky", 32'(err_sticky), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked instruction decode stage for the HybridCore pipeline. It accepts fetched instruction words on a valid/ready interface and extracts opcode, addressing mode, operand register indices, condition code and an extended immediate. Results are held in a two-entry output buffer so fetch can keep streaming through one cycle of execute backpressure. It sits between the fetch unit and the register-read/execute stage, and supports pipeline flush.

## Interface

Parameters:
- WORD_W, 16, instruction width; must equal OP_W + 1 + 2*REG_W
- OP_W, 5, opcode field width
- REG_W, 5, register-index field width
- COND_W, 4, condition field width; must be ≤ REG_W
- DATA_W, 16, width of the extended immediate; must be ≥ REG_W
- IMM_SIGNED, 1, 1 = sign-extend the immediate, 0 = zero-extend
- NUM_OPS, 24, number of legal opcodes (0..NUM_OPS-1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept a word this cycle
- instr  in  WORD_W  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- opcode  out  OP_W  instr[WORD_W-1 -: OP_W]
- addr_mode  out  1  instr[2*REG_W]; 0 = direct (register), 1 = immediate
- reg_idx_a  out  REG_W  instr[2*REG_W-1 -: REG_W]
- reg_idx_b  out  REG_W  instr[REG_W-1:0]
- cond  out  COND_W  instr[COND_W-1:0]
- imm  out  DATA_W  reg_idx_b field extended per IMM_SIGNED
- illegal  out  1  head entry carries an opcode ≥ NUM_OPS (macro-gated)
- err_sticky  out  1  an illegal opcode has been accepted since reset (macro-gated)

## Operation

- Storage: a 2-entry FIFO of decoded records with a count of 0..2. Decoding happens on write; the record fields are stored, not recomputed on read.
- Push: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- in_ready = (count != 2). It is combinational from count only, never from out_ready.
- out_valid = (count != 0). The decoded outputs always present the head entry.
- Simultaneous push and pop at count 1: count stays 1, the head advances to the new record. At count 0, a push makes the record visible next cycle; there is no bypass.
- Flush has priority over push and pop. In the flush cycle, count goes to 0 and any input offered is dropped. in_ready stays per the current count, so a handshake seen by fetch in the flush cycle is discarded by design.
- Immediate: with IMM_SIGNED=1, imm = {{(DATA_W-REG_W){instr[REG_W-1]}}, instr[REG_W-1:0]}. With IMM_SIGNED=0, the upper bits are zero.
- Output fields are meaningful only while out_valid=1. While empty they hold the last popped record (or reset zeros).

## Timing

- Reset (rst_n=0, asynchronous): count=0, out_valid=0, in_ready=1, all field outputs 0, illegal=0, err_sticky=0.
- Latency: 1 cycle from accepted input to out_valid=1 (empty buffer).
- Throughput: 1 instruction/cycle while out_ready=1.
- After two accepted words with out_ready held low, in_ready=0 on the next cycle. It returns to 1 the cycle after the first pop.
- Reset deasserted mid-stream: all state is cleared. The first push is allowed on the first rising edge after release.

## Configuration

- DECODE_ILLEGAL_TRAP_EN defined:
  - Each record stores illegal = (opcode ≥ NUM_OPS).
  - err_sticky sets on the edge where an illegal word is pushed, and clears only on reset.
  - Illegal words are still passed through downstream.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - illegal and err_sticky are tied to 0.
  - No compare logic or storage bit is built.

## Test plan

- Reset with defaults, then push 16'hA9C5 and hold out_ready=1 -> one cycle later out_valid=1, opcode=5'h15, addr_mode=0, reg_idx_a=5'h0E, reg_idx_b=5'h05, cond=4'h5, imm=16'h0005.
- Push 16'h0413 with IMM_SIGNED=1, then again with IMM_SIGNED=0 -> addr_mode=1, reg_idx_b=5'h13; imm=16'hFFF3 (signed) and 16'h0013 (unsigned).
- Hold out_ready=0 and push 3 words back-to-back -> in_ready drops after the 2nd accept and the 3rd is held off. Raise out_ready -> words pop in order, with no loss or duplicate.
- Stream 10 words with out_ready=1 -> 10 outputs in order on consecutive cycles, and count never exceeds 1.
- With 2 entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle word never appears.
- With DECODE_ILLEGAL_TRAP_EN defined, push opcode 5'd30 -> illegal=1 on that record and err_sticky=1 until rst_n pulses low. With the macro undefined -> both outputs stay 0.
